// File: rtl/pipeline_pkg.sv
// Shared definitions for the 4-stage IF/ID/EX/WB pipeline control.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipeline_pkg;

    // Register-file index width (8 architectural registers).
    localparam int REG_W = 3;

    // Opcode loaded into a latch when it is flushed or bubbled.
    localparam logic [7:0] NOP_OPCODE = 8'h00;

    // Sequencer state codes. These values appear on the state port,
    // so keep them stable.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;

    // True for any code the sequencer can legitimately hold.
    function automatic logic is_legal_state(input logic [2:0] s);
        return (s <= ST_PAUSE);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard compare between the ID instruction and the EX/WB writers (no forwarding).
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller decides what to stall.
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : sources read by the instruction in ID
//   ex_rd/wb_rd, ex_wr_reg/wb_wr_reg       : destinations of the EX and WB instructions
//   hazard                                 : some source read in ID is still being written
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             ex_wr_reg,
    input  logic             wb_wr_reg,
    output logic             hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 &&
                     ((ex_wr_reg && (id_rs1 == ex_rd)) || (wb_wr_reg && (id_rs1 == wb_rd)));
    assign rs2_hit = id_uses_rs2 &&
                     ((ex_wr_reg && (id_rs2 == ex_rd)) || (wb_wr_reg && (id_rs2 == wb_rd)));

    assign hazard = rs1_hit || rs2_hit;

endmodule

// File: rtl/pipeline_sequencer.sv
// Cycle sequencer for the IF/ID/EX/WB pipeline: latch enables, flush/bubble, pipe reset, halt.
// Latency: state is registered; outputs decode from state plus the same-cycle hazard term.
// Backpressure: a RAW hazard freezes PC and IF/ID and bubbles ID/EX; PAUSE/HALT freeze everything.
//   Inputs : clk, rst (sync, active high), run_enable, resume, restart, ID/EX/WB register
//            fields, branch_taken (loadPC from WB), halt_seen (HLT decoded in WB)
//   Outputs: pc_inc, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_bubble, pipe_rst,
//            halted, state, stall_count
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_enable,
    input  logic             resume,
    input  logic             restart,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             ex_wr_reg,
    input  logic             wb_wr_reg,
    input  logic             branch_taken,
    input  logic             halt_seen,
    output logic             pc_inc,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_rst,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    // Counter is loaded with one less than the flush length so that the
    // cycle on which it reads zero is the last FLUSH cycle.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [2:0]       flush_cnt_q;
    logic [2:0]       flush_cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic             hazard_raw;
    logic             stall_now;

    hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .wb_rd       (wb_rd),
        .ex_wr_reg   (ex_wr_reg),
        .wb_wr_reg   (wb_wr_reg),
        .hazard      (hazard_raw)
    );

    // Hazards only matter while instructions are genuinely advancing; in
    // FLUSH the ID instruction is being discarded anyway.
    assign stall_now = (state_q == ST_RUN) && hazard_raw;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (run_enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_seen) begin
                    state_d = ST_HALT;
                end else if (branch_taken) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (!run_enable) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_FLUSH: begin
                if (halt_seen) begin
                    state_d = ST_HALT;
                end else if (branch_taken) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            ST_HALT: begin
                if (restart) begin
                    state_d = ST_IDLE;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (run_enable) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!is_legal_state(state_q)) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Cleared on entry to IDLE so the count already reads zero during the
    // pipe_rst cycle rather than one cycle after it.
    always_ff @(posedge clk) begin
        if (rst || (state_d == ST_IDLE)) begin
            stall_q <= '0;
        end else if (stall_now && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_inc       = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_wb_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_rst     = 1'b0;
        halted       = 1'b0;
        case (state_q)
            ST_IDLE: pipe_rst = 1'b1;
            ST_RUN: begin
                // On a hazard, hold PC and IF/ID, let EX/WB drain, and push
                // a NOP into ID/EX in place of the stalled instruction.
                pc_inc       = !stall_now;
                if_id_en     = !stall_now;
                id_ex_en     = 1'b1;
                ex_wb_en     = 1'b1;
                id_ex_bubble = stall_now;
            end
            ST_FLUSH: begin
                pc_inc       = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_wb_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            ST_PAUSE: ;
            default: pipe_rst = 1'b1;
        endcase
    end

    assign state       = state_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

    localparam int FC  = 2;
    localparam int SAT = 255;

    logic       clk = 1'b0;
    logic       rst, run_enable, resume, restart;
    logic [2:0] id_rs1, id_rs2, ex_rd, wb_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_wr_reg, wb_wr_reg;
    logic       branch_taken, halt_seen;
    logic       pc_inc, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_bubble;
    logic       pipe_rst, halted;
    logic [2:0] state;
    logic [7:0] stall_count;

    always #5 clk = ~clk;

    pipeline_sequencer #(.FLUSH_CYCLES(FC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .run_enable(run_enable), .resume(resume), .restart(restart),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .wb_rd(wb_rd), .ex_wr_reg(ex_wr_reg), .wb_wr_reg(wb_wr_reg),
        .branch_taken(branch_taken), .halt_seen(halt_seen),
        .pc_inc(pc_inc), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_wb_en(ex_wb_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .pipe_rst(pipe_rst),
        .halted(halted), .state(state), .stall_count(stall_count)
    );

    // ctl = {pc_inc, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_bubble, pipe_rst, halted}
    typedef struct packed {
        logic [7:0] ctl;
        logic [2:0] st;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: mode 0..4 (idle/run/flush/halt/pause), remaining flush
    // cycles including the current one, and the hazard-stall count.
    int m_mode       = 0;
    int m_flush_left = 0;
    int m_stall      = 0;

    // Does the ID instruction read any register that an older instruction still writes?
    function automatic bit reads_pending();
        logic [2:0] writers[$];
        if (ex_wr_reg) writers.push_back(ex_rd);
        if (wb_wr_reg) writers.push_back(wb_rd);
        foreach (writers[i]) begin
            if (id_uses_rs1 && id_rs1 == writers[i]) return 1'b1;
            if (id_uses_rs2 && id_rs2 == writers[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic tick();
        exp_t e;
        bit   hz;
        hz = (m_mode == 1) && reads_pending();
        case (m_mode)
            0: e.ctl = 8'b0000_0010;
            1: e.ctl = hz ? 8'b0011_0100 : 8'b1111_0000;
            2: e.ctl = 8'b1111_1100;
            3: e.ctl = 8'b0000_0001;
            default: e.ctl = 8'b0000_0000;
        endcase
        e.st  = m_mode[2:0];
        e.cnt = m_stall[7:0];
        exp_q.push_back(e);

        if (rst) begin
            m_mode = 0; m_flush_left = 0; m_stall = 0;
        end else begin
            if (hz && m_stall < SAT) m_stall++;
            case (m_mode)
                0: if (run_enable) m_mode = 1;
                1: begin
                    if (halt_seen) m_mode = 3;
                    else if (branch_taken) begin m_mode = 2; m_flush_left = FC; end
                    else if (!run_enable) m_mode = 4;
                end
                2: begin
                    if (halt_seen) m_mode = 3;
                    else if (branch_taken) m_flush_left = FC;
                    else begin
                        m_flush_left--;
                        if (m_flush_left == 0) m_mode = 1;
                    end
                end
                3: begin
                    if (restart) m_mode = 0;
                    else if (resume) m_mode = 1;
                end
                4: if (run_enable) m_mode = 1;
                default: m_mode = 0;
            endcase
            if (m_mode == 0) m_stall = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet();
        rst = 0; run_enable = 1; resume = 0; restart = 0;
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; wb_rd = 0; ex_wr_reg = 0; wb_wr_reg = 0;
        branch_taken = 0; halt_seen = 0;
    endtask

    task automatic set_rs1_ex_hazard();
        id_rs1 = 3'd3; id_uses_rs1 = 1; ex_rd = 3'd3; ex_wr_reg = 1;
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it
    // against the oldest expectation.
    exp_t got;
    exp_t want;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got  = {pc_inc, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_bubble,
                    pipe_rst, halted, state, stall_count};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs cyc=%0d: got ctl=%b state=%0d cnt=%0d, want ctl=%b state=%0d cnt=%0d",
                         cyc, got.ctl, got.st, got.cnt, want.ctl, want.st, want.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        rst = 1; run_enable = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then IDLE with pipe_rst, then RUN.
        tick(); tick();
        rst = 0; run_enable = 1;
        tick(); tick(); tick();

        // EX hazard one cycle, WB hazard one cycle -> two stalls.
        set_rs1_ex_hazard(); tick();
        ex_wr_reg = 0; wb_rd = 3'd3; wb_wr_reg = 1; tick();
        quiet(); tick();

        // Taken branch: exactly FC flush cycles.
        branch_taken = 1; tick();
        branch_taken = 0; repeat (4) tick();

        // Halt and branch together: HALT wins. Then resume, halt, restart+resume.
        halt_seen = 1; branch_taken = 1; tick();
        quiet(); tick(); tick();
        resume = 1; tick();
        resume = 0; tick();
        halt_seen = 1; tick();
        halt_seen = 0; tick();
        restart = 1; resume = 1; tick();
        quiet(); tick(); tick(); tick();

        // Pause for three cycles with a hazard held.
        set_rs1_ex_hazard(); tick();
        run_enable = 0; repeat (3) tick();
        run_enable = 1; tick(); tick();
        quiet(); tick();

        // Hazard and branch together: stall now, FLUSH next.
        id_rs2 = 3'd5; id_uses_rs2 = 1; wb_rd = 3'd5; wb_wr_reg = 1; branch_taken = 1; tick();
        quiet(); repeat (3) tick();

        // Re-branch inside FLUSH extends it; rst during FLUSH.
        branch_taken = 1; tick(); tick();
        branch_taken = 0; tick();
        rst = 1; tick();
        rst = 0; tick(); tick();
        branch_taken = 1; tick();
        branch_taken = 0; repeat (3) tick();

        // Stall counter saturation.
        set_rs1_ex_hazard(); repeat (262) tick();
        quiet(); tick();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            run_enable   = ($urandom_range(0, 9) != 0);
            resume       = ($urandom_range(0, 3) == 0);
            restart      = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            halt_seen    = ($urandom_range(0, 19) == 0);
            id_rs1       = 3'($urandom_range(0, 7));
            id_rs2       = 3'($urandom_range(0, 7));
            ex_rd        = 3'($urandom_range(0, 7));
            wb_rd        = 3'($urandom_range(0, 7));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            ex_wr_reg    = 1'($urandom_range(0, 1));
            wb_wr_reg    = 1'($urandom_range(0, 1));
            tick();
        end
        quiet();
        tick();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Cycle-level sequencer for the 4-stage IF/ID/EX/WB 8-bit processor pipeline. Generates per-stage latch enables, bubble/flush controls and the pipeline reset. Detects RAW hazards between the instruction in ID and writers in EX/WB, flushes after taken jumps (loadPC), and manages halt/resume/restart. Sits between the clock controller and the stage latches.

## Interface
- FLUSH_CYCLES, 2, cycles of IF/ID flush plus ID/EX bubble after a taken jump (1..7)
- CNT_W, 8, width of the saturating stall counter
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- run_enable  in  1  global run gate (controller_enable)
- resume  in  1  leave HALT and continue from the current PC
- restart  in  1  leave HALT through pipeline reset
- id_rs1, id_rs2  in  3 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  source is actually read
- ex_rd, wb_rd  in  3 each  destinations in EX and WB
- ex_wr_reg, wb_wr_reg  in  1 each  EX/WB instruction writes the register file
- branch_taken  in  1  WB asserts loadPC this cycle
- halt_seen  in  1  WB decoded HLT (HALTED)
- pc_inc  out  1  PC may advance
- if_id_en, id_ex_en, ex_wb_en  out  1 each  latch load enables
- if_id_flush  out  1  load a NOP into IF/ID
- id_ex_bubble  out  1  load a NOP into ID/EX
- pipe_rst  out  1  reset to PC, latches and regfile-side state
- halted  out  1  sequencer is in HALT
- state  out  3  current FSM state code
- stall_count  out  CNT_W  saturating count of hazard-stall cycles since the last pipe_rst

## Operation
- States: IDLE=0, RUN=1, FLUSH=2, HALT=3, PAUSE=4; other codes are illegal and go to IDLE.
- IDLE: pipe_rst=1, all enables 0. Next cycle RUN when run_enable=1.
- RUN: pc_inc and all enables 1 unless a hazard exists.
- Hazard (combinational, RUN only): (id_uses_rs1 && (ex_wr_reg && id_rs1==ex_rd || wb_wr_reg && id_rs1==wb_rd)), likewise for rs2. No forwarding.
- On hazard: pc_inc=0, if_id_en=0, id_ex_bubble=1, id_ex_en=1, ex_wb_en=1; stall_count increments, saturating at all-ones.
- Transition priority in RUN, highest first: halt_seen → HALT; branch_taken → FLUSH (flush counter loaded with FLUSH_CYCLES-1); run_enable=0 → PAUSE; otherwise stay.
- FLUSH: if_id_flush=1, id_ex_bubble=1, pc_inc=1, all enables 1, hazard ignored. Return to RUN once the counter reaches 0. halt_seen in FLUSH → HALT. A new branch_taken reloads the counter.
- HALT: halted=1, all enables and pc_inc 0. restart → IDLE, with priority over resume; otherwise resume → RUN.
- PAUSE: all enables and pc_inc 0, stall_count frozen. run_enable=1 → RUN.
- stall_count clears whenever pipe_rst=1.

## Timing
- Reset values: state=IDLE, pipe_rst=1, every enable 0, pc_inc=0, if_id_flush=0, id_ex_bubble=0, halted=0, stall_count=0, flush counter=0.
- state and flush counter are registered. Outputs are decoded from state. The hazard terms are same-cycle combinational from the inputs.
- Mid-operation rst takes effect at the next edge from any state, including FLUSH and HALT.
- halt_seen and branch_taken together: HALT wins, no flush.
- Hazard and branch_taken together in RUN: the stall outputs apply this cycle, and FLUSH is entered next cycle.
- A FLUSH lasts exactly FLUSH_CYCLES cycles.
- After restart: one IDLE cycle with pipe_rst=1, then RUN if run_enable=1.

## Structure
- Shared package pipeline_pkg holds the state encodings (IDLE/RUN/FLUSH/HALT/PAUSE), the NOP opcode and the register-index width.
- One sub-module, hazard_detect: purely combinational RAW compare, reusable by a future forwarding unit.
- The FSM, flush counter and stall counter stay in pipeline_sequencer.

## Test plan
- Reset then run_enable=1 → one IDLE cycle with pipe_rst=1, then state=1, all enables 1, stall_count=0.
- id_rs1=3, id_uses_rs1=1, ex_rd=3, ex_wr_reg=1 for 1 cycle, then wb_rd=3, wb_wr_reg=1 for 1 cycle → pc_inc=0 and id_ex_bubble=1 for 2 cycles, stall_count=2.
- branch_taken pulse with FLUSH_CYCLES=2 → state=2 for exactly 2 cycles with if_id_flush=1 and id_ex_bubble=1, then state=1.
- halt_seen and branch_taken in the same cycle → state=3, halted=1, no flush. resume → state=1. A later halt followed by restart=resume=1 → IDLE and pipe_rst=1, stall_count=0.
- run_enable dropped for 3 cycles mid-run with a hazard present → state=4, all enables 0, stall_count unchanged. Return to RUN when run_enable=1.
- rst asserted during FLUSH → state=0 at the next edge with all reset values, and the flush counter cleared.
